intr_ctrl: RTL and testbench

INTR_CTRL -- requirements
Module: intr_ctrl

---
 rtl/intr_ctrl.sv | 127 ++++++++++++
 tb/tb_intr_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// Interrupt / launch controller: edge-detected requests, pulse
// sequencing to the processor and a watchdog on the acknowledge.
module intr_ctrl (
    input  logic       clk,
    input  logic       resetN,
    input  logic       StartReq,
    input  logic [3:0] irqReq,
    input  logic [3:0] irqMask,
    input  logic       StageComplete,
    output logic       StartEverything,
    output logic       interrupt,
    output logic [1:0] irqVector,
    output logic [3:0] irqPending,
    output logic       busy,
    output logic       timeoutErr
);

    typedef enum logic [1:0] {
        IDLE,
        START_PULSE,
        IRQ_PULSE,
        WAIT_ACK
    } state_t;

    state_t     state;
    logic       start_prev;
    logic [3:0] irq_prev;
    logic       start_pending;
    logic       pulse_cnt;
    logic       is_irq;
    logic [7:0] wd;

    logic       start_edge;
    logic [3:0] irq_edge;
    logic [3:0] ready;
    logic [3:0] clr;
    logic [1:0] next_vec;
    logic       start_take;

    always_comb begin
        start_edge = StartReq & ~start_prev;
        irq_edge   = irqReq & ~irq_prev;
        ready      = irqPending & irqMask;
        start_take = (state == IDLE) && start_pending;
        clr        = 4'b0000;
        if (state == WAIT_ACK && StageComplete && is_irq)
            clr = 4'b0001 << irqVector;
        // lowest index wins
        next_vec = 2'd0;
        if (ready[0])      next_vec = 2'd0;
        else if (ready[1]) next_vec = 2'd1;
        else if (ready[2]) next_vec = 2'd2;
        else if (ready[3]) next_vec = 2'd3;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state           <= IDLE;
            start_prev      <= 1'b0;
            irq_prev        <= 4'b0000;
            start_pending   <= 1'b0;
            irqPending      <= 4'b0000;
            irqVector       <= 2'd0;
            StartEverything <= 1'b0;
            interrupt       <= 1'b0;
            timeoutErr      <= 1'b0;
            pulse_cnt       <= 1'b0;
            is_irq          <= 1'b0;
            wd              <= 8'd0;
        end else begin
            start_prev    <= StartReq;
            irq_prev      <= irqReq;
            irqPending    <= (irqPending & ~clr) | irq_edge;
            start_pending <= start_edge | (start_pending & ~start_take);
            case (state)
                IDLE: begin
                    if (start_pending) begin
                        state           <= START_PULSE;
                        StartEverything <= 1'b1;
                        is_irq          <= 1'b0;
                        pulse_cnt       <= 1'b0;
                    end else if (|ready) begin
                        state     <= IRQ_PULSE;
                        interrupt <= 1'b1;
                        irqVector <= next_vec;
                        is_irq    <= 1'b1;
                        pulse_cnt <= 1'b0;
                    end
                end
                START_PULSE: begin
                    if (pulse_cnt) begin
                        StartEverything <= 1'b0;
                        state           <= WAIT_ACK;
                        wd              <= 8'd0;
                    end else begin
                        pulse_cnt <= 1'b1;
                    end
                end
                IRQ_PULSE: begin
                    if (pulse_cnt) begin
                        interrupt <= 1'b0;
                        state     <= WAIT_ACK;
                        wd        <= 8'd0;
                    end else begin
                        pulse_cnt <= 1'b1;
                    end
                end
                WAIT_ACK: begin
                    if (StageComplete) begin
                        state <= IDLE;
                    end else begin
                        wd <= wd + 8'd1;
                        // counter hits 255 on this edge: give up, keep pending
                        if (wd == 8'd254) begin
                            timeoutErr <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: hand-computed expectations checked
// with immediate assertions one cycle at a time.
module tb_intr_ctrl;

    logic       clk = 1'b0;
    logic       resetN;
    logic       StartReq;
    logic [3:0] irqReq;
    logic [3:0] irqMask;
    logic       StageComplete;
    logic       StartEverything;
    logic       interrupt;
    logic [1:0] irqVector;
    logic [3:0] irqPending;
    logic       busy;
    logic       timeoutErr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    intr_ctrl dut (
        .clk            (clk),
        .resetN         (resetN),
        .StartReq       (StartReq),
        .irqReq         (irqReq),
        .irqMask        (irqMask),
        .StageComplete  (StageComplete),
        .StartEverything(StartEverything),
        .interrupt      (interrupt),
        .irqVector      (irqVector),
        .irqPending     (irqPending),
        .busy           (busy),
        .timeoutErr     (timeoutErr)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        resetN        = 1'b0;
        StartReq      = 1'b0;
        irqReq        = 4'b0000;
        irqMask       = 4'hF;
        StageComplete = 1'b0;
        tick(3);
        chk("rst_se",   {7'd0, StartEverything}, 8'd0);
        chk("rst_int",  {7'd0, interrupt},       8'd0);
        chk("rst_vec",  {6'd0, irqVector},       8'd0);
        chk("rst_pend", {4'd0, irqPending},      8'd0);
        chk("rst_busy", {7'd0, busy},            8'd0);
        chk("rst_to",   {7'd0, timeoutErr},      8'd0);
        resetN = 1'b1;
        tick(2);

        // start launch
        StartReq = 1'b1;
        tick();
        chk("st_se_n1", {7'd0, StartEverything}, 8'd0);
        tick();
        chk("st_se_n2", {7'd0, StartEverything}, 8'd1);
        chk("st_busy",  {7'd0, busy},            8'd1);
        chk("st_int",   {7'd0, interrupt},       8'd0);
        tick();
        chk("st_se_n3", {7'd0, StartEverything}, 8'd1);
        tick();
        chk("st_se_n4", {7'd0, StartEverything}, 8'd0);
        chk("st_wait",  {7'd0, busy},            8'd1);
        tick(4);
        StageComplete = 1'b1;
        tick();
        StageComplete = 1'b0;
        StartReq      = 1'b0;
        chk("st_done",  {7'd0, busy},            8'd0);
        tick(2);

        // two interrupts, lowest index first
        irqReq = 4'b1010;
        tick();
        chk("p2_pend0", {4'd0, irqPending},      8'h0a);
        tick();
        chk("p2_int1",  {7'd0, interrupt},       8'd1);
        chk("p2_vec1",  {6'd0, irqVector},       8'd1);
        tick(2);
        chk("p2_int0",  {7'd0, interrupt},       8'd0);
        StageComplete = 1'b1;
        tick();
        StageComplete = 1'b0;
        chk("p2_pend1", {4'd0, irqPending},      8'h08);
        chk("p2_idle",  {7'd0, busy},            8'd0);
        tick();
        chk("p2_int3",  {7'd0, interrupt},       8'd1);
        chk("p2_vec3",  {6'd0, irqVector},       8'd3);
        tick(2);
        StageComplete = 1'b1;
        tick();
        StageComplete = 1'b0;
        irqReq        = 4'b0000;
        chk("p2_pend2", {4'd0, irqPending},      8'h00);
        tick(2);

        // start beats interrupt
        StartReq = 1'b1;
        irqReq   = 4'b0001;
        tick(2);
        chk("pr_se",    {7'd0, StartEverything}, 8'd1);
        chk("pr_int",   {7'd0, interrupt},       8'd0);
        tick(2);
        StageComplete = 1'b1;
        tick();
        StageComplete = 1'b0;
        chk("pr_gap",   {7'd0, interrupt},       8'd0);
        chk("pr_gapb",  {7'd0, busy},            8'd0);
        tick();
        chk("pr_int1",  {7'd0, interrupt},       8'd1);
        chk("pr_vec",   {6'd0, irqVector},       8'd0);
        tick(2);
        StageComplete = 1'b1;
        tick();
        StageComplete = 1'b0;
        StartReq      = 1'b0;
        irqReq        = 4'b0000;
        chk("pr_pend",  {4'd0, irqPending},      8'h00);
        tick(2);

        // masked request is deferred
        irqMask = 4'b1011;
        irqReq  = 4'b0100;
        tick();
        chk("mk_pend",  {4'd0, irqPending},      8'h04);
        tick(2);
        chk("mk_int0",  {7'd0, interrupt},       8'd0);
        chk("mk_busy",  {7'd0, busy},            8'd0);
        irqMask = 4'hF;
        tick();
        chk("mk_int1",  {7'd0, interrupt},       8'd1);
        chk("mk_vec",   {6'd0, irqVector},       8'd2);
        StageComplete = 1'b1;
        tick();
        StageComplete = 1'b0;
        chk("mk_int2",  {7'd0, interrupt},       8'd1);
        tick();
        chk("mk_keep",  {4'd0, irqPending},      8'h04);
        chk("mk_wait",  {7'd0, busy},            8'd1);
        StageComplete = 1'b1;
        tick();
        StageComplete = 1'b0;
        irqReq        = 4'b0000;
        chk("mk_clr",   {4'd0, irqPending},      8'h00);
        tick(2);

        // ack timeout
        irqReq = 4'b0001;
        tick(2);
        chk("to_int",   {7'd0, interrupt},       8'd1);
        tick(2);
        tick(254);
        chk("to_pre",   {7'd0, timeoutErr},      8'd0);
        chk("to_preb",  {7'd0, busy},            8'd1);
        tick();
        chk("to_err",   {7'd0, timeoutErr},      8'd1);
        chk("to_idle",  {7'd0, busy},            8'd0);
        chk("to_pend",  {4'd0, irqPending},      8'h01);
        tick();
        chk("to_retry", {7'd0, interrupt},       8'd1);
        chk("to_rvec",  {6'd0, irqVector},       8'd0);

        // reset mid-pulse, request held high through release
        resetN = 1'b0;
        tick();
        chk("ra_int",   {7'd0, interrupt},       8'd0);
        chk("ra_pend",  {4'd0, irqPending},      8'h00);
        chk("ra_busy",  {7'd0, busy},            8'd0);
        chk("ra_to",    {7'd0, timeoutErr},      8'd0);
        resetN = 1'b1;
        tick();
        chk("ra_edge",  {4'd0, irqPending},      8'h01);
        tick();
        chk("ra_int1",  {7'd0, interrupt},       8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
